reset_sequencer: RTL and testbench

//  Parametrised successor to the single-output reset synchroniser. Turns the

---
 rtl/reset_sequencer.sv | 119 +++++++++++
 tb/tb_reset_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged, pclk-synchronous resets released after a filtered MMCM lock
// Lock glitch filter, ordered per-channel release, soft-reset re-run and saturating lock-loss count.
module reset_sequencer #(
    parameter int NUM_CH      = 3,
    parameter int LOCK_FILTER = 16,
    parameter int STAGE_DELAY = 10,
    parameter int LOSS_W      = 4
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              locked,
    input  logic              soft_rst,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic [LOSS_W-1:0] loss_cnt
);

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    localparam logic [7:0] LF      = 8'(LOCK_FILTER);
    localparam logic [7:0] LF_M1   = 8'(LOCK_FILTER - 1);
    localparam logic [7:0] SD_M1   = 8'(STAGE_DELAY - 1);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [7:0]          filt_q, filt_d;
    logic [7:0]          stg_q, stg_d;
    logic [2:0]          ch_q, ch_d;
    logic [NUM_CH-1:0]   rst_out_q, rst_out_d;
    logic                ready_q, ready_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                locked_s;

    assign sync_d   = {sync_q[0], locked};
    assign locked_s = sync_q[1];

    always_comb begin
        state_d   = state_q;
        filt_d    = filt_q;
        stg_d     = stg_q;
        ch_d      = ch_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        loss_d    = loss_q;
        case (state_q)
            HOLD: begin
                rst_out_d = '1;
                ready_d   = 1'b0;
                if (!locked_s) begin
                    filt_d = 8'd0;
                end else if (filt_q == LF) begin
                    state_d = RELEASE;
                    filt_d  = 8'd0;
                    stg_d   = 8'd0;
                    ch_d    = 3'd0;
                end else begin
                    filt_d = filt_q + 8'd1;
                end
            end
            default: begin
                if (!locked_s) begin
                    state_d   = HOLD;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    filt_d    = 8'd0;
                    if (loss_q != '1) loss_d = loss_q + 1'b1;
                end else if (soft_rst) begin
                    // Lock is known good, so skip most of the filter on re-entry.
                    state_d   = HOLD;
                    rst_out_d = '1;
                    ready_d   = 1'b0;
                    filt_d    = LF_M1;
                end else if (state_q == RELEASE) begin
                    if (stg_q == SD_M1) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (ch_q == 3'(k)) rst_out_d[k] = 1'b0;
                        end
                        stg_d = 8'd0;
                        ch_d  = ch_q + 3'd1;
                        if (ch_q == LAST_CH) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        stg_d = stg_q + 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= HOLD;
            sync_q    <= 2'b00;
            filt_q    <= 8'd0;
            stg_q     <= 8'd0;
            ch_q      <= 3'd0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            stg_q     <= stg_d;
            ch_q      <= ch_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            loss_q    <= loss_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign ready    = ready_q;
    assign loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed self-checking bench for reset_sequencer
// Default instance plus a single-channel instance sharing the same stimulus.
module tb_reset_sequencer;

    localparam int LF = 16;
    localparam int SD = 10;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic [3:0] loss_cnt;
    logic [0:0] rst_out1;
    logic       ready1;
    logic [3:0] loss_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    reset_sequencer dut (
        .pclk(pclk), .rst(rst), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_out), .ready(ready), .loss_cnt(loss_cnt)
    );

    reset_sequencer #(.NUM_CH(1)) dut1 (
        .pclk(pclk), .rst(rst), .locked(locked), .soft_rst(soft_rst),
        .rst_out(rst_out1), .ready(ready1), .loss_cnt(loss_cnt1)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Raise locked; the next edge is edge 0 of the release timeline.
    task automatic run_seq(input string tag, input int loss_exp);
        logic [2:0] exp_r;
        locked = 1'b1;
        for (int e = 0; e <= 50; e++) begin
            tick();
            for (int k = 0; k < 3; k++) exp_r[k] = (e < 2 + LF + (k + 1) * SD);
            chk({tag, "_rst_out"}, 32'(rst_out), 32'(exp_r));
            chk({tag, "_ready"}, 32'(ready), 32'(e >= 48));
            chk({tag, "_loss"}, 32'(loss_cnt), 32'(loss_exp));
            chk({tag, "_ready_1ch"}, 32'(ready1), 32'(e >= 28));
        end
    endtask

    initial begin
        tick();
        chk("reset_rst_out", 32'(rst_out), 32'h7);
        chk("reset_ready", 32'(ready), 32'h0);
        chk("reset_loss", 32'(loss_cnt), 32'h0);
        rst = 1'b0;

        // Glitchy lock in HOLD never completes the filter.
        for (int i = 0; i < 60; i++) begin
            locked = (i % 10 != 9);
            tick();
            chk("glitch_rst_out", 32'(rst_out), 32'h7);
            chk("glitch_loss", 32'(loss_cnt), 32'h0);
        end

        locked = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_seq("seq1", 0);

        // Lock loss in RUN for three cycles.
        locked = 1'b0;
        tick();
        tick();
        chk("drop_e2_rst_out", 32'(rst_out), 32'h0);
        tick();
        chk("drop_e3_rst_out", 32'(rst_out), 32'h7);
        chk("drop_e3_ready", 32'(ready), 32'h0);
        chk("drop_e3_loss", 32'(loss_cnt), 32'h1);
        run_seq("seq2", 1);

        // Soft reset in RUN: fast re-entry, counter untouched.
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft_rst_out", 32'(rst_out), 32'h7);
        chk("soft_ready", 32'(ready), 32'h0);
        chk("soft_loss", 32'(loss_cnt), 32'h1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("soft_seq_rst_out", 32'(rst_out), (i >= 12) ? 32'h6 : 32'h7);
        end

        // Lock loss and soft_rst together with ch_idx = 1: lock loss wins.
        locked = 1'b0;
        tick();
        tick();
        chk("both_pre_rst_out", 32'(rst_out), 32'h6);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("both_rst_out", 32'(rst_out), 32'h7);
        chk("both_loss", 32'(loss_cnt), 32'h2);
        run_seq("seq3", 2);

        // Asynchronous reset between edges during RELEASE.
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("async_pre_rst_out", 32'(rst_out), 32'h6);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(rst_out), 32'h7);
        chk("async_ready", 32'(ready), 32'h0);
        chk("async_loss", 32'(loss_cnt), 32'h0);
        chk("async_ready_1ch", 32'(ready1), 32'h0);
        tick();
        rst = 1'b0;

        // Twenty lock losses saturate the counter.
        for (int n = 1; n <= 20; n++) begin
            locked = 1'b1;
            for (int i = 0; i < 25; i++) tick();
            locked = 1'b0;
            for (int i = 0; i < 4; i++) tick();
            chk("sat_loss", 32'(loss_cnt), 32'((n > 15) ? 15 : n));
            chk("sat_loss_1ch", 32'(loss_cnt1), 32'((n > 15) ? 15 : n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
